// File: rtl/sram_like_arbiter.sv
// Two-port (inst/data) arbiter in front of a single SRAM-like downstream port.
// One transaction outstanding at a time; data has priority, bounded by a starvation counter for inst.
module sram_like_arbiter #(
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    state_t     state, state_next;
    logic       owner_inst, owner_inst_next;
    logic [3:0] starve_cnt, starve_cnt_next;
    logic       inst_wins;

    assign inst_wins  = inst_req && (!data_req || (starve_cnt == STARVE_LIMIT));
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner_inst <= 1'b0;
            starve_cnt <= 4'd0;
        end else begin
            state      <= state_next;
            owner_inst <= owner_inst_next;
            starve_cnt <= starve_cnt_next;
        end
    end

    always_comb begin
        state_next      = state;
        owner_inst_next = owner_inst;
        starve_cnt_next = starve_cnt;
        mem_req         = 1'b0;
        mem_wr          = 1'b0;
        mem_size        = 2'd0;
        mem_addr        = 32'd0;
        mem_wdata       = 32'd0;
        inst_addr_ok    = 1'b0;
        inst_data_ok    = 1'b0;
        data_addr_ok    = 1'b0;
        data_data_ok    = 1'b0;

        case (state)
            IDLE: begin
                if (inst_req || data_req) begin
                    state_next      = ADDR;
                    owner_inst_next = inst_wins;
                    if (inst_wins)
                        starve_cnt_next = 4'd0;
                    else if (inst_req && (starve_cnt < STARVE_LIMIT))
                        starve_cnt_next = starve_cnt + 4'd1;
                end
            end
            ADDR: begin
                mem_req   = 1'b1;
                mem_wr    = owner_inst ? inst_wr    : data_wr;
                mem_size  = owner_inst ? inst_size  : data_size;
                mem_addr  = owner_inst ? inst_addr  : data_addr;
                mem_wdata = owner_inst ? inst_wdata : data_wdata;
                if (mem_addr_ok) begin
                    inst_addr_ok = owner_inst;
                    data_addr_ok = !owner_inst;
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (mem_data_ok) begin
                    inst_data_ok = owner_inst;
                    data_data_ok = !owner_inst;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Reset is synchronous, so the old state is still visible during the reset cycle; mask it.
        if (rst) begin
            mem_req      = 1'b0;
            mem_wr       = 1'b0;
            mem_size     = 2'd0;
            mem_addr     = 32'd0;
            mem_wdata    = 32'd0;
            inst_addr_ok = 1'b0;
            inst_data_ok = 1'b0;
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized bench for sram_like_arbiter against a transaction-level reference model,
// plus short directed sequences for the starvation pattern, a single inst read and reset mid-transaction.
module tb_sram_like_arbiter;

    localparam int STARVE_MAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [31:0] inst_rdata, data_rdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_addr_ok, mem_data_ok;

    int checks = 0;
    int errors = 0;

    // Reference model: one in-flight transaction record plus a count of data wins over a waiting inst.
    bit m_in_flight;
    bit m_accepted;
    bit m_inst;
    int m_waits;

    bit grant_seen;
    bit grant_inst;

    always #5 clk = ~clk;

    sram_like_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_rdata   (inst_rdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, observed, expected);
        end
    endtask

    // Checks all outputs mid-cycle, then advances the model at the rising edge and returns at the next falling edge.
    task automatic runCycle();
        bit          presenting;
        bit          returning;
        bit          winner_inst;
        logic [31:0] e_addr, e_wdata;
        logic [1:0]  e_size;
        logic        e_wr;
        #1;
        presenting = m_in_flight && !m_accepted && !rst;
        returning  = m_in_flight && m_accepted && !rst && mem_data_ok;
        e_wr    = presenting ? (m_inst ? inst_wr    : data_wr)    : 1'b0;
        e_size  = presenting ? (m_inst ? inst_size  : data_size)  : 2'd0;
        e_addr  = presenting ? (m_inst ? inst_addr  : data_addr)  : 32'd0;
        e_wdata = presenting ? (m_inst ? inst_wdata : data_wdata) : 32'd0;
        checkOutput("mem_req",      32'(mem_req),      32'(presenting));
        checkOutput("mem_wr",       32'(mem_wr),       32'(e_wr));
        checkOutput("mem_size",     32'(mem_size),     32'(e_size));
        checkOutput("mem_addr",     mem_addr,          e_addr);
        checkOutput("mem_wdata",    mem_wdata,         e_wdata);
        checkOutput("inst_addr_ok", 32'(inst_addr_ok), 32'(presenting && mem_addr_ok && m_inst));
        checkOutput("data_addr_ok", 32'(data_addr_ok), 32'(presenting && mem_addr_ok && !m_inst));
        checkOutput("inst_data_ok", 32'(inst_data_ok), 32'(returning && m_inst));
        checkOutput("data_data_ok", 32'(data_data_ok), 32'(returning && !m_inst));
        checkOutput("inst_rdata",   inst_rdata,        mem_rdata);
        checkOutput("data_rdata",   data_rdata,        mem_rdata);
        grant_seen = inst_addr_ok || data_addr_ok;
        grant_inst = inst_addr_ok;

        @(posedge clk);
        if (rst) begin
            m_in_flight = 0;
            m_accepted  = 0;
            m_waits     = 0;
        end else if (!m_in_flight) begin
            if (inst_req || data_req) begin
                winner_inst = inst_req && (!data_req || m_waits == STARVE_MAX);
                m_in_flight = 1;
                m_accepted  = 0;
                m_inst      = winner_inst;
                if (winner_inst)
                    m_waits = 0;
                else if (inst_req)
                    m_waits = (m_waits + 1 > STARVE_MAX) ? STARVE_MAX : m_waits + 1;
            end
        end else if (!m_accepted) begin
            if (mem_addr_ok)
                m_accepted = 1;
        end else if (mem_data_ok) begin
            m_in_flight = 0;
        end
        @(negedge clk);
    endtask

    // A requester that owns a not-yet-accepted transaction keeps its request and fields stable.
    task automatic applyStimulus();
        bit hold_inst;
        bit hold_data;
        hold_inst = m_in_flight && !m_accepted && m_inst;
        hold_data = m_in_flight && !m_accepted && !m_inst;
        rst = ($urandom_range(0, 39) == 0);
        if (!hold_inst) begin
            inst_req   = 1'($urandom_range(0, 1));
            inst_wr    = 1'($urandom_range(0, 1));
            inst_size  = 2'($urandom_range(0, 3));
            inst_addr  = $urandom;
            inst_wdata = $urandom;
        end
        if (!hold_data) begin
            data_req   = 1'($urandom_range(0, 1));
            data_wr    = 1'($urandom_range(0, 1));
            data_size  = 2'($urandom_range(0, 3));
            data_addr  = $urandom;
            data_wdata = $urandom;
        end
        mem_addr_ok = ($urandom_range(0, 2) == 0);
        mem_data_ok = 1'($urandom_range(0, 1));
        mem_rdata   = $urandom;
    endtask

    task automatic quietInputs();
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
    endtask

    initial begin
        int grants_got[8];
        int n_grants;
        bit expected_inst;

        m_in_flight = 0;
        m_accepted  = 0;
        m_inst      = 0;
        m_waits     = 0;
        rst = 1;
        quietInputs();
        mem_data_ok = 1;
        @(negedge clk);
        runCycle();
        runCycle();

        // Single inst read from the boot vector with a one-cycle memory.
        rst = 0;
        quietInputs();
        inst_req = 1; inst_addr = 32'hBFC00000; mem_addr_ok = 1; mem_rdata = 32'hCAFEF00D;
        runCycle();
        #1;
        checkOutput("boot_mem_req",  32'(mem_req), 32'd1);
        checkOutput("boot_mem_addr", mem_addr, 32'hBFC00000);
        checkOutput("boot_addr_ok",  32'(inst_addr_ok), 32'd1);
        runCycle();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        #1;
        checkOutput("boot_data_ok", 32'(inst_data_ok), 32'd1);
        checkOutput("boot_rdata",   inst_rdata, 32'hCAFEF00D);
        checkOutput("boot_dstrobe", 32'(data_data_ok), 32'd0);
        runCycle();

        // Both ports requesting continuously: data wins STARVE_MAX times, then inst once.
        rst = 1;
        quietInputs();
        runCycle();
        rst = 0;
        inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
        for (int i = 0; i < 8; i++) grants_got[i] = 2;
        n_grants = 0;
        for (int c = 0; c < 27; c++) begin
            runCycle();
            if (grant_seen && n_grants < 8) begin
                grants_got[n_grants] = grant_inst ? 1 : 0;
                n_grants++;
            end
        end
        for (int i = 0; i < 8; i++) begin
            expected_inst = ((i % (STARVE_MAX + 1)) == STARVE_MAX);
            checkOutput($sformatf("grant_seq_%0d", i), 32'(grants_got[i]), 32'(expected_inst));
        end

        // Reset while waiting for data, then a stray data_ok two cycles later.
        rst = 1;
        quietInputs();
        runCycle();
        rst = 0;
        data_req = 1; data_addr = 32'h80000010; mem_addr_ok = 1;
        runCycle();
        runCycle();
        rst = 1; data_req = 0; mem_addr_ok = 0;
        runCycle();
        rst = 0;
        runCycle();
        mem_data_ok = 1;
        #1;
        checkOutput("stray_data_ok", 32'(data_data_ok), 32'd0);
        runCycle();
        mem_data_ok = 0; inst_req = 1; inst_addr = 32'h00001000;
        runCycle();
        runCycle();

        for (int c = 0; c < 2000; c++) begin
            applyStimulus();
            runCycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
